seq_detect_scheduler: RTL and testbench

- Shares one 01[0*]1 sequence-detector instance between two requesters.
- Each requester submits a WORD_W-bit test word. The scheduler arbitrates round-robin, clears the detector, and serializes the word MSB-first onto the detector input.
- Detections (z pulses) are counted over a fixed observation window. A per-word result is returned with a valid/ready response handshake.
- Sits between the stimulus sources and the detector; the detector's own 7-segment counter runs unmodified alongside.

---
 rtl/seq_detect_pkg.sv | 28 ++
 rtl/rr_arbiter2.sv | 36 +++
 rtl/seq_detect_scheduler.sv | 133 +++++++++++++
 tb/tb_seq_detect_scheduler.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_detect_pkg.sv
// Shared types and constants for the sequence-detector scheduler slice.
package seq_detect_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    SHIFT,
    DRAIN,
    RESP
  } sched_state_t;

  localparam int WORD_W_DEF = 16;
  localparam int LAT_DEF    = 2;
  localparam int CNT_W_DEF  = 5;

  // 7-segment codes (gfedcba, active-high) shared with the detector's display counter.
  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: combinational one-hot grant, pointer moves
// to the other requester whenever a grant is taken.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic [1:0] valid_i,
  output logic [1:0] grant_o
);

  logic ptr_q;

  // Grant the pointer-preferred requester if valid, otherwise the other one.
  always_comb begin
    grant_o = 2'b00;
    if (en_i) begin
      if (ptr_q == 1'b0) begin
        if (valid_i[0])      grant_o = 2'b01;
        else if (valid_i[1]) grant_o = 2'b10;
      end else begin
        if (valid_i[1])      grant_o = 2'b10;
        else if (valid_i[0]) grant_o = 2'b01;
      end
    end
  end

  // After a grant, prefer the requester that was not served.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= 1'b0;
    end else if (|grant_o) begin
      ptr_q <= grant_o[0];
    end
  end

endmodule

// File: rtl/seq_detect_scheduler.sv
// Shares one 01[0*]1 detector between two requesters: arbitrates a word,
// clears the detector, shifts the word MSB-first, counts det_z pulses over
// a WORD_W-cycle window aligned to the detector latency, and returns the count.
module seq_detect_scheduler
  import seq_detect_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int LAT    = LAT_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid_i,
  input  logic [WORD_W-1:0] req_data0_i,
  input  logic [WORD_W-1:0] req_data1_i,
  output logic [1:0]        req_ready_o,
  output logic              det_rst_o,
  output logic              det_ena_o,
  output logic              det_bit_o,
  input  logic              det_z_i,
  output logic              rsp_valid_o,
  output logic              rsp_id_o,
  output logic [CNT_W-1:0]  rsp_count_o,
  input  logic              rsp_ready_i
);

  localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [IDX_W-1:0] LAST_BIT   = IDX_W'(WORD_W - 1);
  localparam logic [IDX_W-1:0] LAST_DRAIN = IDX_W'(LAT - 1);
  localparam logic [IDX_W-1:0] WIN_START  = IDX_W'(LAT);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  sched_state_t      state_q;
  logic [WORD_W-1:0] shift_q;
  logic              id_q;
  logic [IDX_W-1:0]  idx_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              det_bit_q;
  logic              det_ena_q;
  logic              rsp_valid_q;
  logic              arb_en;
  logic              accept;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + 1'b1;
  endfunction

  assign arb_en = (state_q == IDLE) && !rst;
  assign accept = |req_ready_o;

  rr_arbiter2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .en_i    (arb_en),
    .valid_i (req_valid_i),
    .grant_o (req_ready_o)
  );

  assign det_rst_o   = rst || (state_q == CLEAR);
  assign det_ena_o   = det_ena_q;
  assign det_bit_o   = det_bit_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_id_o    = id_q;
  assign rsp_count_o = cnt_q;

  // Word shift register: loaded on grant, advanced once per serialized bit.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && accept) begin
      shift_q <= req_ready_o[1] ? req_data1_i : req_data0_i;
    end else if (state_q == CLEAR || state_q == SHIFT) begin
      shift_q <= shift_q << 1;
    end
  end

  // Scheduler FSM with registered detector drive, window counting and response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      id_q        <= 1'b0;
      idx_q       <= '0;
      cnt_q       <= '0;
      det_bit_q   <= 1'b1;
      det_ena_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            id_q    <= req_ready_o[1];
            state_q <= CLEAR;
          end
        end
        CLEAR: begin
          cnt_q     <= '0;
          idx_q     <= '0;
          det_bit_q <= shift_q[WORD_W-1];
          det_ena_q <= 1'b1;
          state_q   <= SHIFT;
        end
        SHIFT: begin
          // The first LAT cycles still show the detector's pre-word output.
          if (idx_q >= WIN_START && det_z_i) cnt_q <= sat_inc(cnt_q);
          if (idx_q == LAST_BIT) begin
            idx_q     <= '0;
            det_bit_q <= 1'b1;
            state_q   <= DRAIN;
          end else begin
            idx_q     <= idx_q + 1'b1;
            det_bit_q <= shift_q[WORD_W-1];
          end
        end
        DRAIN: begin
          if (det_z_i) cnt_q <= sat_inc(cnt_q);
          if (idx_q == LAST_DRAIN) begin
            det_ena_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_detect_scheduler.sv
// Bench for seq_detect_scheduler: detector stand-ins drive det_z, a
// scoreboard holds expected {id, count, accept cycle}, a monitor checks responses.
module tb_seq_detect_scheduler;

  localparam int W    = 16;
  localparam int LAT  = 2;
  localparam int CW   = 5;
  localparam int CW_S = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [1:0]    req_valid;
  logic [W-1:0]  d0, d1;
  logic [1:0]    req_ready;
  logic          det_rst, det_ena, det_bit, det_z;
  logic          rsp_valid, rsp_id, rsp_ready;
  logic [CW-1:0] rsp_count;

  logic [1:0]      req_valid_s;
  logic [W-1:0]    d0_s, d1_s;
  logic [1:0]      req_ready_s;
  logic            det_rst_s, det_ena_s, det_bit_s, det_z_s;
  logic            rsp_valid_s, rsp_id_s, rsp_ready_s;
  logic [CW_S-1:0] rsp_count_s;

  seq_detect_scheduler #(.WORD_W(W), .LAT(LAT), .CNT_W(CW)) u_dut (
    .clk(clk), .rst(rst), .req_valid_i(req_valid), .req_data0_i(d0), .req_data1_i(d1),
    .req_ready_o(req_ready), .det_rst_o(det_rst), .det_ena_o(det_ena), .det_bit_o(det_bit),
    .det_z_i(det_z), .rsp_valid_o(rsp_valid), .rsp_id_o(rsp_id), .rsp_count_o(rsp_count),
    .rsp_ready_i(rsp_ready)
  );

  seq_detect_scheduler #(.WORD_W(W), .LAT(LAT), .CNT_W(CW_S)) u_sat (
    .clk(clk), .rst(rst), .req_valid_i(req_valid_s), .req_data0_i(d0_s), .req_data1_i(d1_s),
    .req_ready_o(req_ready_s), .det_rst_o(det_rst_s), .det_ena_o(det_ena_s), .det_bit_o(det_bit_s),
    .det_z_i(det_z_s), .rsp_valid_o(rsp_valid_s), .rsp_id_o(rsp_id_s), .rsp_count_o(rsp_count_s),
    .rsp_ready_i(rsp_ready_s)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int acc_total = 0;

  task automatic check_eq(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference: search the word for 0, then a later 1, then a later 1; restart after each hit.
  function automatic int find_bit(input logic [W-1:0] w, input int from, input logic v);
    for (int i = from; i >= 0; i--) if (w[i] == v) return i;
    return -1;
  endfunction

  function automatic int ref_count(input logic [W-1:0] w, input int cw);
    int n, p, a, b, c, mx;
    n = 0;
    p = W - 1;
    while (p >= 0) begin
      a = find_bit(w, p, 1'b0);
      if (a < 0) break;
      b = find_bit(w, a - 1, 1'b1);
      if (b < 0) break;
      c = find_bit(w, b - 1, 1'b1);
      if (c < 0) break;
      n++;
      p = c - 1;
    end
    mx = (1 << cw) - 1;
    return (n > mx) ? mx : n;
  endfunction

  // Detector stand-in: one-step transition, returns {z, next_state}.
  function automatic logic [2:0] det_step(input logic [1:0] st, input logic b);
    case (st)
      2'd0:    return b ? {1'b0, 2'd0} : {1'b0, 2'd1};
      2'd1:    return b ? {1'b0, 2'd2} : {1'b0, 2'd1};
      default: return b ? {1'b1, 2'd0} : {1'b0, 2'd2};
    endcase
  endfunction

  logic [1:0]     dst, dst_s;
  logic [LAT-1:0] dpipe, dpipe_s;
  logic           noise_q, noise_en;

  always @(posedge clk) begin
    logic [2:0] r;
    if (det_rst) begin
      dst   <= 2'd0;
      dpipe <= '0;
    end else begin
      r = det_step(dst, det_bit);
      dst   <= r[1:0];
      dpipe <= {dpipe[LAT-2:0], r[2]};
    end
    noise_q <= ($urandom_range(0, 3) == 0);
  end
  assign det_z = dpipe[LAT-1] | (noise_en & noise_q & ~det_ena);

  always @(posedge clk) begin
    logic [2:0] r;
    if (det_rst_s) begin
      dst_s   <= 2'd0;
      dpipe_s <= '0;
    end else begin
      r = det_step(dst_s, det_bit_s);
      dst_s   <= r[1:0];
      dpipe_s <= {dpipe_s[LAT-2:0], r[2]};
    end
  end
  assign det_z_s = dpipe_s[LAT-1];

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic id;
    int   cnt;
    int   acc_cyc;
  } exp_t;

  exp_t sb[$];
  logic grant_log[$];

  // Acceptance watcher: push the expected result for every handshake.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (req_ready != 2'b00)
        check_eq("grant_onehot_valid", {30'd0, req_ready & ~req_valid, 1'b0} | ($countones(req_ready) == 1 ? 0 : 1), 0);
      for (int i = 0; i < 2; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          e.id      = i[0];
          e.cnt     = ref_count((i == 0) ? d0 : d1, CW);
          e.acc_cyc = cyc + 1;
          sb.push_back(e);
          grant_log.push_back(i[0]);
          acc_total++;
        end
      end
    end
  end

  // Response monitor: compare every presented response against the scoreboard front.
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    if (!rst && rsp_valid) begin
      if (sb.size() == 0) begin
        check_eq("rsp_unexpected", 1, 0);
      end else begin
        if (!prev_valid) check_eq("rsp_latency", cyc - sb[0].acc_cyc, 1 + W + LAT);
        check_eq("rsp_id", rsp_id, sb[0].id);
        check_eq("rsp_count", rsp_count, sb[0].cnt);
        check_eq("no_grant_in_resp", req_ready, 0);
        if (rsp_ready) void'(sb.pop_front());
      end
    end
    prev_valid = rst ? 1'b0 : rsp_valid;
  end

  task automatic wait_empty(input string name, input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    check_eq({name, "_drained"}, sb.size(), 0);
    #1;
  endtask

  task automatic send(input int i, input logic [W-1:0] w);
    int n;
    n = 0;
    if (i == 0) d0 = w; else d1 = w;
    req_valid[i] = 1'b1;
    @(negedge clk);
    while (!req_ready[i] && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq($sformatf("send%0d_grant", i), req_ready[i], 1);
    @(posedge clk);
    #1;
    req_valid[i] = 1'b0;
  endtask

  task automatic sat_word(input logic [W-1:0] w);
    int n;
    n = 0;
    d0_s = w;
    req_valid_s = 2'b01;
    @(negedge clk);
    while (!req_ready_s[0] && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("sat_grant", req_ready_s, 2'b01);
    @(posedge clk);
    #1;
    req_valid_s = 2'b00;
    n = 0;
    @(negedge clk);
    while (!rsp_valid_s && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("sat_rsp_valid", rsp_valid_s, 1);
    check_eq("sat_rsp_id", rsp_id_s, 0);
    check_eq("sat_count", rsp_count_s, ref_count(w, CW_S));
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] rand_word();
    logic [3:0] nib;
    case ($urandom_range(0, 3))
      0: return W'($urandom);
      1: begin
        nib = 4'($urandom);
        return {4{nib}};
      end
      2: return W'($urandom & $urandom);
      default: return W'($urandom | $urandom);
    endcase
  endfunction

  initial begin
    #(64'd900000);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] w;
    logic [1:0]   acc;
    int           n, base, gbase;

    rst = 1'b1; req_valid = 2'b00; d0 = '0; d1 = '0; rsp_ready = 1'b1; noise_en = 1'b0;
    req_valid_s = 2'b00; d0_s = '0; d1_s = '0; rsp_ready_s = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_req_ready", req_ready, 0);
    check_eq("rst_rsp_valid", rsp_valid, 0);
    check_eq("rst_rsp_id", rsp_id, 0);
    check_eq("rst_rsp_count", rsp_count, 0);
    check_eq("rst_det_bit", det_bit, 1);
    check_eq("rst_det_ena", det_ena, 0);
    check_eq("rst_det_rst", det_rst, 1);
    check_eq("rst_sat_det_ena", det_ena_s, 0);
    check_eq("rst_sat_det_bit", det_bit_s, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("idle_det_rst", det_rst, 0);

    // Single word from requester 0 with detailed serial checks.
    @(posedge clk); #1;
    w = 16'h5000;
    d0 = w;
    req_valid = 2'b01;
    @(negedge clk);
    check_eq("t1_ready", req_ready, 2'b01);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("t1_clear_det_rst", det_rst, 1);
    check_eq("t1_clear_det_bit", det_bit, 1);
    check_eq("t1_clear_ready", req_ready, 0);
    @(posedge clk); #1;
    req_valid = 2'b00;
    for (int k = 0; k < W; k++) begin
      @(negedge clk);
      check_eq($sformatf("t1_bit%0d", k), det_bit, w[W-1-k]);
      check_eq($sformatf("t1_ena%0d", k), det_ena, 1);
    end
    wait_empty("t1", 200);

    // All-ones then all-zeros: nothing to detect, order preserved.
    send(0, 16'hFFFF);
    send(0, 16'h0000);
    wait_empty("t2", 200);

    // Response held off for 10 cycles while both requesters wait.
    rsp_ready = 1'b0;
    send(0, 16'h0123);
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("t3_rsp_valid", rsp_valid, 1);
    @(posedge clk); #1;
    d0 = 16'hAAAA; d1 = 16'h5555;
    req_valid = 2'b11;
    repeat (10) @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    req_valid = 2'b00;
    wait_empty("t3", 200);

    // Reset during SHIFT idx=7 aborts the word and returns the pointer to 0.
    send(0, 16'h5555);
    repeat (8) @(posedge clk);
    #1;
    check_eq("t4_mid_shift_ena", det_ena, 1);
    rst = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    d0 = 16'h5000; d1 = 16'h5500;
    gbase = grant_log.size();
    base = acc_total;
    req_valid = 2'b11;
    @(negedge clk);
    check_eq("t4_det_ena", det_ena, 0);
    check_eq("t4_det_bit", det_bit, 1);
    check_eq("t4_det_rst", det_rst, 0);
    check_eq("t4_rsp_valid", rsp_valid, 0);
    check_eq("t4_ptr_grant", req_ready, 2'b01);

    // Continuous contention: grants alternate starting with requester 0.
    n = 0;
    while (acc_total < base + 4 && n < 400) begin
      @(posedge clk);
      n++;
    end
    #1;
    req_valid = 2'b00;
    check_eq("t5_grants", grant_log.size() - gbase, 4);
    for (int k = 0; k < 4; k++)
      if (gbase + k < grant_log.size())
        check_eq($sformatf("t5_alt%0d", k), grant_log[gbase + k], k % 2);
    wait_empty("t5", 300);

    // Randomized traffic with out-of-window det_z noise and random back-pressure.
    noise_en = 1'b1;
    base = acc_total;
    for (int c = 0; c < 4000 && acc_total < base + 50; c++) begin
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
        if (acc[i]) begin
          req_valid[i] = 1'($urandom_range(0, 1));
          if (i == 0) d0 = rand_word(); else d1 = rand_word();
        end else if (req_valid[i]) begin
          if ($urandom_range(0, 9) == 0) req_valid[i] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          req_valid[i] = 1'b1;
          if (i == 0) d0 = rand_word(); else d1 = rand_word();
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    check_eq("t6_accepted", acc_total - base >= 50, 1);
    wait_empty("t6", 500);
    noise_en = 1'b0;

    // Narrow counter saturates instead of wrapping.
    sat_word(16'h5555);
    sat_word(16'h5000);
    sat_word(16'h5500);

    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
